// File: rtl/menu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : menu_pkg                                                     |
// | Description : Shared defaults, button indices and ADC index decode.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package menu_pkg;

    localparam int C_INPUT_TYPES   = 3;
    localparam int C_SCALING_MODES = 3;
    localparam int C_NUM_ADC       = 2;
    localparam int C_HOLD_CYCLES   = 50_000_000;

    localparam int C_NUM_BUTTONS   = 4;
    localparam int C_ADC_IDX_W_MAX = 8;

    typedef enum logic [1:0] {
        BTN_MODE  = 2'd0,
        BTN_SCALE = 2'd1,
        BTN_HEX   = 2'd2,
        BTN_ADC   = 2'd3
    } button_e;

    // Only the mode button's long press restores the reset settings.
    localparam logic [C_NUM_BUTTONS-1:0] C_RESTORE_MASK = 4'b0001;

    typedef struct packed {
        logic [C_ADC_IDX_W_MAX-1:0] adc_sel;
        logic                       successive_approx;
    } adc_decode_t;

    // Index 0 = no ADC; odd index = direct mode, even nonzero = successive approx.
    function automatic adc_decode_t adc_decode(input logic [C_ADC_IDX_W_MAX-1:0] index);
        adc_decode_t result;
        result.adc_sel = {1'b0, index[C_ADC_IDX_W_MAX-1:1]}
                       + {{(C_ADC_IDX_W_MAX-1){1'b0}}, index[0]};
        result.successive_approx = (index != '0) && !index[0];
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/menu_button.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : menu_button                                                  |
// | Description : Button synchroniser, press edge detect and long-press timer. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module menu_button
    import menu_pkg::*;
#(
    parameter int HOLD_CYCLES = C_HOLD_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic i_button,
    output logic o_press,
    output logic o_long_press
);

    localparam int                 C_CNT_W   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [C_CNT_W-1:0] C_CNT_MAX = C_CNT_W'(HOLD_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_sync_valid;
    logic               r_armed;
    logic               r_prev;
    logic               r_done;
    logic [C_CNT_W-1:0] r_cnt;

    logic               w_level;
    logic               w_at_max;

    // A button must be seen released after reset before it counts as pressed.
    assign w_level      = r_sync2 & r_armed;
    assign w_at_max     = (r_cnt == C_CNT_MAX);
    assign o_press      = w_level & ~r_prev;
    assign o_long_press = w_level & w_at_max & ~r_done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1      <= 1'b0;
            r_sync2      <= 1'b0;
            r_sync_valid <= 1'b0;
            r_armed      <= 1'b0;
            r_prev       <= 1'b0;
            r_done       <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_sync1      <= i_button;
            r_sync2      <= r_sync1;
            r_sync_valid <= 1'b1;
            r_armed      <= r_armed | (r_sync_valid & ~r_sync1);
            r_prev       <= w_level;
            if (!w_level) begin
                r_cnt  <= '0;
                r_done <= 1'b0;
            end else if (!w_at_max) begin
                r_cnt  <= r_cnt + C_CNT_W'(1);
            end else begin
                r_done <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/menu_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : menu_controller                                              |
// | Description : Four-button menu: source, scaling, HEX/BCD and ADC selection.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module menu_controller
    import menu_pkg::*;
#(
    parameter int INPUT_TYPES   = C_INPUT_TYPES,
    parameter int SCALING_MODES = C_SCALING_MODES,
    parameter int NUM_ADC       = C_NUM_ADC,
    parameter int HOLD_CYCLES   = C_HOLD_CYCLES
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_mode,
    input  logic                             scale_val_in,
    input  logic                             hex_BCD_in,
    input  logic                             ADC_sel_in,
    input  logic                             lock,
    output logic [$clog2(INPUT_TYPES)-1:0]   out_sel,
    output logic [$clog2(SCALING_MODES)-1:0] scale_sel,
    output logic                             hex_BCD_sel,
    output logic [$clog2(NUM_ADC+1)-1:0]     ADC_sel,
    output logic                             successive_approx,
    output logic                             settings_changed
);

    localparam int C_OUT_W   = $clog2(INPUT_TYPES);
    localparam int C_SCALE_W = $clog2(SCALING_MODES);
    localparam int C_ADC_W   = $clog2(NUM_ADC + 1);
    localparam int C_IDX_W   = $clog2(2 * NUM_ADC + 1);

    localparam logic [C_OUT_W-1:0]   C_OUT_LAST     = C_OUT_W'(INPUT_TYPES - 1);
    localparam logic [C_SCALE_W-1:0] C_SCALE_LAST   = C_SCALE_W'(SCALING_MODES - 1);
    localparam logic [C_IDX_W-1:0]   C_ADC_IDX_IDLE = '0;
    localparam logic [C_IDX_W-1:0]   C_ADC_IDX_LAST = C_IDX_W'(2 * NUM_ADC);

    logic [C_NUM_BUTTONS-1:0] w_raw;
    logic [C_NUM_BUTTONS-1:0] w_press;
    logic [C_NUM_BUTTONS-1:0] w_long;
    logic [C_NUM_BUTTONS-1:0] w_step;
    logic                     w_restore;
    logic                     w_changed;

    logic [C_OUT_W-1:0]       r_out_sel;
    logic [C_OUT_W-1:0]       w_out_sel_nxt;
    logic [C_SCALE_W-1:0]     r_scale_sel;
    logic [C_SCALE_W-1:0]     w_scale_sel_nxt;
    logic                     r_hex_bcd;
    logic                     w_hex_bcd_nxt;
    logic [C_IDX_W-1:0]       r_adc_idx;
    logic [C_IDX_W-1:0]       w_adc_idx_nxt;
    logic                     r_changed;
    adc_decode_t              w_dec_cur;
    adc_decode_t              w_dec_nxt;

    assign w_raw = {ADC_sel_in, hex_BCD_in, scale_val_in, in_mode};

    generate
        for (genvar g = 0; g < C_NUM_BUTTONS; g++) begin : g_button
            menu_button #(
                .HOLD_CYCLES (HOLD_CYCLES)
            ) u_button (
                .clk          (clk),
                .reset        (reset),
                .i_button     (w_raw[g]),
                .o_press      (w_press[g]),
                .o_long_press (w_long[g])
            );
        end
    endgenerate

    // Lock drops pulses outright; nothing is remembered for later.
    assign w_step    = w_press & {C_NUM_BUTTONS{~lock}};
    assign w_restore = ~lock & (|(w_long & C_RESTORE_MASK));

    always_comb begin
        w_out_sel_nxt   = r_out_sel;
        w_scale_sel_nxt = r_scale_sel;
        w_hex_bcd_nxt   = r_hex_bcd;
        w_adc_idx_nxt   = r_adc_idx;
        if (w_restore) begin
            w_out_sel_nxt   = '0;
            w_scale_sel_nxt = '0;
            w_hex_bcd_nxt   = 1'b0;
            w_adc_idx_nxt   = C_ADC_IDX_IDLE;
        end else begin
            if (w_step[BTN_MODE]) begin
                w_out_sel_nxt = (r_out_sel == C_OUT_LAST) ? '0 : r_out_sel + C_OUT_W'(1);
            end
            if (w_step[BTN_SCALE]) begin
                w_scale_sel_nxt = (r_scale_sel == C_SCALE_LAST) ? '0 : r_scale_sel + C_SCALE_W'(1);
            end
            if (w_step[BTN_HEX]) begin
                w_hex_bcd_nxt = ~r_hex_bcd;
            end
            if (w_step[BTN_ADC]) begin
                w_adc_idx_nxt = (r_adc_idx == C_ADC_IDX_LAST) ? C_ADC_IDX_IDLE
                                                              : r_adc_idx + C_IDX_W'(1);
            end
        end
    end

    assign w_dec_cur = adc_decode(C_ADC_IDX_W_MAX'(r_adc_idx));
    assign w_dec_nxt = adc_decode(C_ADC_IDX_W_MAX'(w_adc_idx_nxt));

    assign w_changed = (w_out_sel_nxt != r_out_sel) | (w_scale_sel_nxt != r_scale_sel)
                     | (w_hex_bcd_nxt != r_hex_bcd) | (w_dec_nxt != w_dec_cur);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_sel   <= '0;
            r_scale_sel <= '0;
            r_hex_bcd   <= 1'b0;
            r_adc_idx   <= C_ADC_IDX_IDLE;
            r_changed   <= 1'b0;
        end else begin
            r_out_sel   <= w_out_sel_nxt;
            r_scale_sel <= w_scale_sel_nxt;
            r_hex_bcd   <= w_hex_bcd_nxt;
            r_adc_idx   <= w_adc_idx_nxt;
            r_changed   <= w_changed;
        end
    end

    assign out_sel           = r_out_sel;
    assign scale_sel         = r_scale_sel;
    assign hex_BCD_sel       = r_hex_bcd;
    assign ADC_sel           = w_dec_cur.adc_sel[C_ADC_W-1:0];
    assign successive_approx = w_dec_cur.successive_approx;
    assign settings_changed  = r_changed;

endmodule
`default_nettype wire

// File: tb/tb_menu_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_menu_controller                                           |
// | Description : Randomised and directed bench against a sampled-input model. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_menu_controller;

    localparam int INPUT_TYPES   = 3;
    localparam int SCALING_MODES = 3;
    localparam int NUM_ADC       = 2;
    localparam int HOLD_CYCLES   = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic in_mode = 1'b0;
    logic scale_val_in = 1'b0;
    logic hex_BCD_in = 1'b0;
    logic ADC_sel_in = 1'b0;
    logic lock = 1'b0;
    logic [$clog2(INPUT_TYPES)-1:0]   out_sel;
    logic [$clog2(SCALING_MODES)-1:0] scale_sel;
    logic                             hex_BCD_sel;
    logic [$clog2(NUM_ADC+1)-1:0]     ADC_sel;
    logic                             successive_approx;
    logic                             settings_changed;

    menu_controller #(
        .INPUT_TYPES   (INPUT_TYPES),
        .SCALING_MODES (SCALING_MODES),
        .NUM_ADC       (NUM_ADC),
        .HOLD_CYCLES   (HOLD_CYCLES)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .in_mode           (in_mode),
        .scale_val_in      (scale_val_in),
        .hex_BCD_in        (hex_BCD_in),
        .ADC_sel_in        (ADC_sel_in),
        .lock              (lock),
        .out_sel           (out_sel),
        .scale_sel         (scale_sel),
        .hex_BCD_sel       (hex_BCD_sel),
        .ADC_sel           (ADC_sel),
        .successive_approx (successive_approx),
        .settings_changed  (settings_changed)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int sc_count = 0;

    // Reference model: settings as plain integers, per-button run of high samples.
    int       m_out, m_scale, m_hex, m_idx, m_changed;
    int       m_run[4];
    bit       m_blocked[4];
    bit [4:0] m_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        else n_pass++;
    endtask

    function automatic logic [3:0] raw_now();
        return {ADC_sel_in, hex_BCD_in, scale_val_in, in_mode};
    endfunction

    task automatic set_btn(input int b, input logic v);
        case (b)
            0:       in_mode      = v;
            1:       scale_val_in = v;
            2:       hex_BCD_in   = v;
            default: ADC_sel_in   = v;
        endcase
    endtask

    task automatic model_clear();
        m_out = 0; m_scale = 0; m_hex = 0; m_idx = 0; m_changed = 0;
        m_q.delete();
        for (int b = 0; b < 4; b++) begin
            m_run[b]     = 0;
            m_blocked[b] = raw_now()[b];
        end
    endtask

    // A sample seen at edge t acts at edge t+2: press on a run of 1, restore on a run of HOLD_CYCLES.
    task automatic model_edge();
        logic [3:0] raw;
        bit [4:0]   due;
        bit [4:0]   ev;
        int         o_out, o_scale, o_hex, o_idx;
        raw = raw_now();
        if (!reset) begin
            model_clear();
            return;
        end
        due = (m_q.size() == 2) ? m_q.pop_front() : 5'b0;
        ev  = 5'b0;
        for (int b = 0; b < 4; b++) begin
            if (m_blocked[b]) begin
                if (!raw[b]) m_blocked[b] = 1'b0;
                m_run[b] = 0;
            end else begin
                m_run[b] = raw[b] ? m_run[b] + 1 : 0;
            end
            if (m_run[b] == 1) ev[b] = 1'b1;
        end
        if (m_run[0] == HOLD_CYCLES) ev[4] = 1'b1;
        m_q.push_back(ev);
        o_out = m_out; o_scale = m_scale; o_hex = m_hex; o_idx = m_idx;
        if (!lock) begin
            if (due[4]) begin
                m_out = 0; m_scale = 0; m_hex = 0; m_idx = 0;
            end else begin
                if (due[0]) m_out   = (m_out + 1) % INPUT_TYPES;
                if (due[1]) m_scale = (m_scale + 1) % SCALING_MODES;
                if (due[2]) m_hex   = 1 - m_hex;
                if (due[3]) m_idx   = (m_idx + 1) % (2 * NUM_ADC + 1);
            end
        end
        m_changed = (o_out != m_out || o_scale != m_scale || o_hex != m_hex || o_idx != m_idx) ? 1 : 0;
    endtask

    task automatic compare();
        check("out_sel", out_sel, m_out);
        check("scale_sel", scale_sel, m_scale);
        check("hex_BCD_sel", hex_BCD_sel, m_hex);
        check("ADC_sel", ADC_sel, (m_idx + 1) / 2);
        check("successive_approx", successive_approx, (m_idx != 0 && m_idx % 2 == 0) ? 1 : 0);
        check("settings_changed", settings_changed, m_changed);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        compare();
        if (settings_changed === 1'b1) sc_count++;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic tap(input int b);
        set_btn(b, 1'b1);
        idle(3);
        set_btn(b, 1'b0);
        idle(3);
    endtask

    task automatic assert_reset(input string tag);
        reset = 1'b0;
        #1;
        check({tag, "_out_sel"}, out_sel, 0);
        check({tag, "_scale_sel"}, scale_sel, 0);
        check({tag, "_hex_BCD_sel"}, hex_BCD_sel, 0);
        check({tag, "_ADC_sel"}, ADC_sel, 0);
        check({tag, "_successive_approx"}, successive_approx, 0);
        check({tag, "_settings_changed"}, settings_changed, 0);
        model_clear();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sc0;
        int exp_out[4] = '{1, 2, 0, 1};
        int exp_adc[5] = '{1, 1, 2, 2, 0};
        int exp_sa[5]  = '{0, 1, 0, 1, 0};

        #2;
        assert_reset("reset");
        idle(3);
        reset = 1'b1;
        idle(4);

        sc0 = sc_count;
        for (int i = 0; i < 4; i++) begin
            tap(0);
            check("mode_seq_out_sel", out_sel, exp_out[i]);
        end
        check("mode_seq_pulses", sc_count - sc0, 4);

        for (int i = 0; i < 5; i++) begin
            tap(3);
            check("adc_seq_ADC_sel", ADC_sel, exp_adc[i]);
            check("adc_seq_sa", successive_approx, exp_sa[i]);
        end

        tap(0);
        tap(1);
        tap(2);
        check("pre_hold_out_sel", out_sel, 2);
        check("pre_hold_scale_sel", scale_sel, 1);
        check("pre_hold_hex", hex_BCD_sel, 1);
        in_mode = 1'b1;
        idle(3);
        sc0 = sc_count;
        idle(17);
        in_mode = 1'b0;
        idle(4);
        check("long_press_pulses", sc_count - sc0, 1);
        check("long_press_out_sel", out_sel, 0);
        check("long_press_scale_sel", scale_sel, 0);
        check("long_press_hex", hex_BCD_sel, 0);

        lock = 1'b1;
        sc0 = sc_count;
        for (int b = 0; b < 4; b++) set_btn(b, 1'b1);
        idle(3);
        for (int b = 0; b < 4; b++) set_btn(b, 1'b0);
        idle(3);
        lock = 1'b0;
        idle(2);
        check("lock_pulses", sc_count - sc0, 0);
        check("lock_out_sel", out_sel, 0);
        tap(1);
        check("unlock_scale_sel", scale_sel, 1);

        sc0 = sc_count;
        in_mode = 1'b1; scale_val_in = 1'b1; hex_BCD_in = 1'b1;
        idle(3);
        in_mode = 1'b0; scale_val_in = 1'b0; hex_BCD_in = 1'b0;
        idle(3);
        check("simul_pulses", sc_count - sc0, 1);
        check("simul_out_sel", out_sel, 1);
        check("simul_scale_sel", scale_sel, 2);
        check("simul_hex", hex_BCD_sel, 1);

        hex_BCD_in = 1'b1;
        idle(4);
        assert_reset("midpress_reset");
        idle(2);
        reset = 1'b1;
        idle(6);
        check("held_through_reset_hex", hex_BCD_sel, 0);
        hex_BCD_in = 1'b0;
        idle(3);
        tap(2);
        check("repress_hex", hex_BCD_sel, 1);

        in_mode = 1'b1;
        idle(4);
        assert_reset("midhold_reset");
        idle(2);
        reset = 1'b1;
        idle(2);
        tap(1);
        idle(8);
        check("hold_cancel_scale_sel", scale_sel, 1);
        check("hold_cancel_out_sel", out_sel, 0);
        in_mode = 1'b0;
        idle(4);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 11) == 0) in_mode      = ~in_mode;
            if ($urandom_range(0, 5) == 0)  scale_val_in = ~scale_val_in;
            if ($urandom_range(0, 5) == 0)  hex_BCD_in   = ~hex_BCD_in;
            if ($urandom_range(0, 5) == 0)  ADC_sel_in   = ~ADC_sel_in;
            if ($urandom_range(0, 24) == 0) lock         = ~lock;
            cycle();
        end
        in_mode = 1'b0; scale_val_in = 1'b0; hex_BCD_in = 1'b0; ADC_sel_in = 1'b0; lock = 1'b0;
        idle(5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
